// File: rtl/eth_pkg.sv
// Shared Ethernet CRC32 constants, FCS appender state type and the dibit CRC step
// used by both the tx appender and the rx checker.
package eth_pkg;

  localparam logic [31:0] CRC32_POLY = 32'h04C1_1DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFF_FFFF;
  localparam int unsigned FCS_DIBITS = 16;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    FCS,
    GAP
  } fcs_state_t;

  // Two serial MSB-first CRC shifts; d[0] is the earlier bit on the wire.
  function automatic logic [31:0] crc32_dibit_step(input logic [31:0] crc, input logic [1:0] d);
    logic [31:0] c;
    c = crc;
    for (int i = 0; i < 2; i++) begin
      if (c[31] ^ d[i]) begin
        c = {c[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    return c;
  endfunction

  // Top two bits of an FCS word in wire order (bit 31 goes out first on d[0]).
  function automatic logic [1:0] fcs_top_dibit(input logic [31:0] fcs);
    return {fcs[30], fcs[31]};
  endfunction

endpackage

// File: rtl/eth_fcs_appender.sv
// Transmit-side FCS appender on the RMII dibit path: forwards a frame with one
// cycle of latency, appends the inverted CRC32 MSB first, then holds off for the IFG.
module eth_fcs_appender
  import eth_pkg::*;
#(
  parameter int unsigned IFG_DIBITS = 48
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  output logic       axiir,
  output logic       axiov,
  output logic [1:0] axiod,
  output logic       overrun
);

  localparam int unsigned CNT_RANGE = (IFG_DIBITS + 1 > FCS_DIBITS) ? IFG_DIBITS + 1 : FCS_DIBITS;
  localparam int unsigned CNT_W     = $clog2(CNT_RANGE);
  localparam int unsigned GAP_LAST_I = (IFG_DIBITS == 0) ? 0 : IFG_DIBITS - 1;
  localparam logic [CNT_W-1:0] FCS_LAST = CNT_W'(FCS_DIBITS - 2);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_LAST_I);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam bit HAS_GAP = (IFG_DIBITS != 0);

  fcs_state_t       state_q;
  logic [31:0]      crc_q;
  logic [31:0]      crc_d;
  logic [31:0]      shift_q;
  logic [CNT_W-1:0] cnt_q;
  logic             axiov_q;
  logic [1:0]       axiod_q;
  logic             overrun_q;

  assign axiir = (state_q == IDLE) || (state_q == DATA);

  // A frame always starts its CRC from the init value, whatever the previous frame left.
  always_comb begin
    crc_d = crc32_dibit_step((state_q == IDLE) ? CRC32_INIT : crc_q, axiid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      crc_q     <= CRC32_INIT;
      shift_q   <= '0;
      cnt_q     <= '0;
      axiov_q   <= 1'b0;
      axiod_q   <= 2'b00;
      overrun_q <= 1'b0;
    end else begin
      axiov_q   <= 1'b0;
      axiod_q   <= 2'b00;
      overrun_q <= axiiv && !axiir;
      case (state_q)
        IDLE: begin
          crc_q <= CRC32_INIT;
          if (axiiv) begin
            state_q <= DATA;
            crc_q   <= crc_d;
            axiov_q <= 1'b1;
            axiod_q <= axiid;
          end
        end
        DATA: begin
          if (axiiv) begin
            crc_q   <= crc_d;
            axiov_q <= 1'b1;
            axiod_q <= axiid;
          end else begin
            // First FCS dibit leaves on this edge; the shifter keeps the remaining 30 bits.
            state_q <= FCS;
            shift_q <= {~crc_q[29:0], 2'b00};
            cnt_q   <= '0;
            axiov_q <= 1'b1;
            axiod_q <= fcs_top_dibit(~crc_q);
          end
        end
        FCS: begin
          axiov_q <= 1'b1;
          axiod_q <= fcs_top_dibit(shift_q);
          shift_q <= {shift_q[29:0], 2'b00};
          cnt_q   <= cnt_q + CNT_ONE;
          if (cnt_q == FCS_LAST) begin
            cnt_q   <= '0;
            state_q <= HAS_GAP ? GAP : IDLE;
          end
        end
        GAP: begin
          cnt_q <= cnt_q + CNT_ONE;
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign axiov   = axiov_q;
  assign axiod   = axiod_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_eth_fcs_appender.sv
// Randomized bench for eth_fcs_appender: a 48-dibit-IFG instance and a zero-IFG
// instance, checked against a polynomial long-division CRC model.
module tb_eth_fcs_appender;

  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic clk = 1'b0;
  logic rst;
  logic a_iv, a_ir, a_ov, a_or;
  logic [1:0] a_id, a_od;
  logic b_iv, b_ir, b_ov, b_or;
  logic [1:0] b_id, b_od;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  eth_fcs_appender #(.IFG_DIBITS(48)) dut (
    .clk(clk), .rst(rst), .axiiv(a_iv), .axiid(a_id), .axiir(a_ir),
    .axiov(a_ov), .axiod(a_od), .overrun(a_or)
  );

  eth_fcs_appender #(.IFG_DIBITS(0)) dut_noifg (
    .clk(clk), .rst(rst), .axiiv(b_iv), .axiid(b_id), .axiir(b_ir),
    .axiov(b_ov), .axiod(b_od), .overrun(b_or)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int u, input logic v, input logic [1:0] d);
    if (u == 0) begin a_iv = v; a_id = d; end
    else begin b_iv = v; b_id = d; end
  endtask

  // {axiir, axiov, axiod, overrun}
  function automatic logic [4:0] obs(input int u);
    return (u == 0) ? {a_ir, a_ov, a_od, a_or} : {b_ir, b_ov, b_od, b_or};
  endfunction

  // CRC as (M * x^32 + INIT * x^n) mod G by long division over the wire-order bit stream.
  function automatic logic [31:0] model_rem(input logic [1:0] dib[$]);
    bit a[$];
    logic [32:0] gen;
    logic [31:0] r;
    int n;
    gen = {1'b1, POLY};
    foreach (dib[i]) begin
      a.push_back(dib[i][0]);
      a.push_back(dib[i][1]);
    end
    n = a.size();
    for (int i = 0; i < 32; i++) a.push_back(1'b0);
    for (int i = 0; i < 32; i++) a[i] = a[i] ^ 1'b1;
    for (int i = 0; i < n; i++) begin
      if (a[i]) begin
        for (int j = 0; j <= 32; j++) a[i+j] = a[i+j] ^ gen[32-j];
      end
    end
    for (int k = 0; k < 32; k++) r[31-k] = a[n+k];
    return r;
  endfunction

  function automatic logic [1:0] fcs_dib(input logic [31:0] f, input int k);
    return {f[30-2*k], f[31-2*k]};
  endfunction

  task automatic rand_frame(input int n, output logic [1:0] q[$]);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(2'($urandom));
  endtask

  // Sends one frame, checks echo, contiguous FCS, IFG length and overrun pulses.
  task automatic send_frame(input int u, input string tag, input logic [1:0] fr[$],
                            input logic [31:0] exp_fcs, input int ovr_at, input int ovr_n,
                            output logic [1:0] txo[$]);
    logic [4:0] o;
    int ovr, gap, spurious, ifg;
    ifg = (u == 0) ? 48 : 0;
    txo = {};
    ovr = 0;
    spurious = 0;
    foreach (fr[i]) begin
      drive(u, 1'b1, fr[i]);
      tick();
      o = obs(u);
      check({tag, "_dat"}, 64'({o[3], o[2:1]}), 64'({1'b1, fr[i]}));
      if (o[3]) txo.push_back(o[2:1]);
      if (o[0]) ovr++;
    end
    drive(u, 1'b0, 2'b00);
    for (int t = 0; t < 16; t++) begin
      tick();
      o = obs(u);
      check({tag, "_fcs"}, 64'({o[3], o[2:1]}), 64'({1'b1, fcs_dib(exp_fcs, t)}));
      if (t == 0) check({tag, "_ir_fcs"}, 64'(o[4]), 64'(0));
      if (o[3]) txo.push_back(o[2:1]);
      if (o[0]) ovr++;
      if (t >= ovr_at && t < ovr_at + ovr_n) drive(u, 1'b1, 2'($urandom));
      else drive(u, 1'b0, 2'b00);
    end
    gap = 0;
    o = obs(u);
    while (!o[4] && gap < 1000) begin
      gap++;
      tick();
      o = obs(u);
      if (o[3] || o[2:1] != 2'b00) spurious++;
      if (o[0]) ovr++;
    end
    check({tag, "_gap"}, 64'(gap), 64'(ifg));
    check({tag, "_gapidle"}, 64'(spurious), 64'(0));
    check({tag, "_ovr"}, 64'(ovr), 64'(ovr_n));
  endtask

  initial begin
    logic [1:0] fr[$];
    logic [1:0] txo[$];
    logic [4:0] o;
    logic [7:0] b;
    string s;

    rst = 1'b1;
    drive(0, 1'b0, 2'b00);
    drive(1, 1'b0, 2'b00);
    repeat (3) tick();
    o = obs(0);
    check("rst_ir", 64'(o[4]), 64'(1));
    check("rst_ov", 64'(o[3]), 64'(0));
    check("rst_od", 64'(o[2:1]), 64'(0));
    check("rst_ovr", 64'(o[0]), 64'(0));
    rst = 1'b0;
    tick();

    // Standard check string, bits MSB first per byte.
    s = "123456789";
    fr = {};
    for (int i = 0; i < s.len(); i++) begin
      b = s[i];
      for (int j = 0; j < 4; j++) fr.push_back({b[6-2*j], b[7-2*j]});
    end
    send_frame(0, "check", fr, 32'hFC89_1918, 99, 0, txo);

    fr = {2'b00};
    send_frame(0, "one", fr, ~model_rem(fr), 99, 0, txo);

    rand_frame(256, fr);
    send_frame(0, "res", fr, ~model_rem(fr), 99, 0, txo);
    check("residue", 64'(model_rem(txo)), 64'(32'hC704_DD7B));

    rand_frame(20, fr);
    send_frame(0, "b2b", fr, ~model_rem(fr), 5, 3, txo);

    for (int k = 0; k < 5; k++) begin
      rand_frame(int'($urandom_range(1, 40)), fr);
      send_frame(0, "rnd", fr, ~model_rem(fr), int'($urandom_range(0, 12)), int'($urandom_range(0, 2)), txo);
    end

    // Abort at FCS dibit 7.
    rand_frame(12, fr);
    foreach (fr[i]) begin
      drive(0, 1'b1, fr[i]);
      tick();
    end
    drive(0, 1'b0, 2'b00);
    repeat (8) tick();
    o = obs(0);
    check("abort_pre", 64'({o[3], o[2:1]}), 64'({1'b1, fcs_dib(~model_rem(fr), 7)}));
    rst = 1'b1;
    tick();
    o = obs(0);
    check("abort_ov", 64'(o[3]), 64'(0));
    check("abort_ir", 64'(o[4]), 64'(1));
    rst = 1'b0;
    rand_frame(9, fr);
    send_frame(0, "after_rst", fr, ~model_rem(fr), 99, 0, txo);

    // Zero-IFG instance: frames follow each other with no idle cycle.
    rand_frame(7, fr);
    send_frame(1, "noifg0", fr, ~model_rem(fr), 99, 0, txo);
    rand_frame(15, fr);
    send_frame(1, "noifg1", fr, ~model_rem(fr), 2, 2, txo);
    rand_frame(1, fr);
    send_frame(1, "noifg2", fr, ~model_rem(fr), 99, 0, txo);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
